// File: rtl/video_ega_bus_bridge.sv
// CPU-to-EGA bus bridge: sequences byte/word CPU transactions into registered
// address/data/strobe cycles with a settle cycle before strobes and write hold.
module video_ega_bus_bridge #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iReq,
  input  logic        iWe,
  input  logic        iIo,
  input  logic        iWord,
  input  logic [19:0] iAddr,
  input  logic [15:0] iWrData,
  output logic        oBusy,
  output logic        oAck,
  output logic [15:0] oRdData,
  output logic [19:0] oAddr,
  output logic [7:0]  oWrData,
  output logic        oWrMem,
  output logic        oRdMem,
  output logic        oWrIo,
  output logic        oRdIo,
  input  logic [7:0]  iRdData,
  input  logic        iSel
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, WAIT, HOLD} state_t;

  typedef struct packed {
    logic        we;
    logic        io;
    logic        word;
    logic [19:0] addr;
    logic [15:0] wdata;
  } req_t;

  localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

  state_t     state;
  req_t       req;
  logic       idx;
  logic       hold_cnt;
  logic [7:0] tcnt;
  logic [7:0] lo;

  logic       byte_done;
  logic [7:0] cap;

  // A read byte finishes on iSel or when the wait budget runs out (iSel wins
  // in the last cycle); a write byte finishes after its second hold cycle.
  always_comb begin
    byte_done = 1'b0;
    cap       = 8'hFF;
    case (state)
      WAIT: begin
        if (iSel) begin
          byte_done = 1'b1;
          cap       = iRdData;
        end else if (tcnt == TLAST) begin
          byte_done = 1'b1;
        end
      end
      HOLD:    byte_done = hold_cnt;
      default: byte_done = 1'b0;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state    <= IDLE;
      req      <= '0;
      idx      <= 1'b0;
      hold_cnt <= 1'b0;
      tcnt     <= '0;
      lo       <= '0;
      oBusy    <= 1'b0;
      oAck     <= 1'b0;
      oRdData  <= '0;
      oAddr    <= '0;
      oWrData  <= '0;
      oWrMem   <= 1'b0;
      oRdMem   <= 1'b0;
      oWrIo    <= 1'b0;
      oRdIo    <= 1'b0;
    end else begin
      oAck   <= 1'b0;
      oWrMem <= 1'b0;
      oRdMem <= 1'b0;
      oWrIo  <= 1'b0;
      oRdIo  <= 1'b0;

      case (state)
        IDLE: begin
          if (iReq) begin
            req     <= '{we: iWe, io: iIo, word: iWord, addr: iAddr, wdata: iWrData};
            idx     <= 1'b0;
            oAddr   <= iAddr;
            oWrData <= iWrData[7:0];
            oBusy   <= 1'b1;
            state   <= SETUP;
          end
        end
        SETUP: begin
          oWrMem <=  req.we && !req.io;
          oRdMem <= !req.we && !req.io;
          oWrIo  <=  req.we &&  req.io;
          oRdIo  <= !req.we &&  req.io;
          state  <= STROBE;
        end
        STROBE: begin
          if (req.we) begin
            hold_cnt <= 1'b0;
            state    <= HOLD;
          end else begin
            tcnt  <= '0;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (!byte_done) tcnt <= tcnt + 8'd1;
        end
        HOLD: hold_cnt <= 1'b1;
        default: state <= IDLE;
      endcase

      if (byte_done) begin
        if (req.word && !idx) begin
          idx     <= 1'b1;
          lo      <= cap;
          oAddr   <= req.addr + 20'd1;
          oWrData <= req.wdata[15:8];
          state   <= SETUP;
        end else begin
          state <= IDLE;
          oBusy <= 1'b0;
          oAck  <= 1'b1;
          if (!req.we) oRdData <= req.word ? {cap, lo} : {8'h00, cap};
        end
      end
    end
  end

endmodule

// File: tb/tb_video_ega_bus_bridge.sv
// Directed bench for video_ega_bus_bridge; cycle n is the period after the nth
// rising edge following the request, with inputs driven and outputs sampled 1ns in.
module tb_video_ega_bus_bridge;

  logic        iClk = 1'b0;
  logic        iRst, iReq, iWe, iIo, iWord, iSel;
  logic [19:0] iAddr;
  logic [15:0] iWrData;
  logic [7:0]  iRdData;
  logic        oBusy, oAck, oWrMem, oRdMem, oWrIo, oRdIo;
  logic [15:0] oRdData;
  logic [19:0] oAddr;
  logic [7:0]  oWrData;

  int tests = 0;
  int fails = 0;
  int n_wm = 0, n_rm = 0, n_wi = 0, n_ri = 0, n_ack = 0;
  int s_wm, s_rm, s_ri, s_ack;

  video_ega_bus_bridge #(.TIMEOUT(15)) dut (
    .iClk(iClk), .iRst(iRst), .iReq(iReq), .iWe(iWe), .iIo(iIo), .iWord(iWord),
    .iAddr(iAddr), .iWrData(iWrData), .oBusy(oBusy), .oAck(oAck), .oRdData(oRdData),
    .oAddr(oAddr), .oWrData(oWrData), .oWrMem(oWrMem), .oRdMem(oRdMem),
    .oWrIo(oWrIo), .oRdIo(oRdIo), .iRdData(iRdData), .iSel(iSel)
  );

  always #5 iClk = ~iClk;

  // pulse counters, sampled mid-cycle
  always @(negedge iClk) begin
    if (oWrMem) n_wm++;
    if (oRdMem) n_rm++;
    if (oWrIo)  n_wi++;
    if (oRdIo)  n_ri++;
    if (oAck)   n_ack++;
  end

  task automatic cyc();
    @(posedge iClk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic we, input logic io, input logic word,
                     input logic [19:0] a, input logic [15:0] d);
    iReq = 1'b1; iWe = we; iIo = io; iWord = word; iAddr = a; iWrData = d;
  endtask

  initial begin
    iRst = 1'b1; iReq = 1'b0; iWe = 1'b0; iIo = 1'b0; iWord = 1'b0;
    iAddr = '0; iWrData = '0; iRdData = '0; iSel = 1'b0;
    repeat (3) cyc();
    chk("rst_addr", 32'(oAddr), 32'h0);
    chk("rst_wdata", 32'(oWrData), 32'h0);
    chk("rst_busy", 32'(oBusy), 32'h0);
    chk("rst_ack", 32'(oAck), 32'h0);
    chk("rst_rdata", 32'(oRdData), 32'h0);
    chk("rst_strobes", 32'({oWrMem, oRdMem, oWrIo, oRdIo}), 32'h0);
    iRst = 1'b0;
    cyc();

    // byte mem read A0010, responder returns 5A the cycle after the strobe
    req(1'b0, 1'b0, 1'b0, 20'hA0010, 16'h0);
    chk("br_c0_busy", 32'(oBusy), 32'h0);
    cyc(); iReq = 1'b0;
    chk("br_c1_addr", 32'(oAddr), 32'hA0010);
    chk("br_c1_busy", 32'(oBusy), 32'h1);
    chk("br_c1_rm", 32'(oRdMem), 32'h0);
    cyc();
    chk("br_c2_rm", 32'(oRdMem), 32'h1);
    chk("br_c2_addr", 32'(oAddr), 32'hA0010);
    cyc();
    chk("br_c3_rm", 32'(oRdMem), 32'h0);
    iSel = 1'b1; iRdData = 8'h5A;
    cyc(); iSel = 1'b0; iRdData = 8'h00;
    chk("br_c4_ack", 32'(oAck), 32'h1);
    chk("br_c4_rdata", 32'(oRdData), 32'h005A);
    chk("br_c4_busy", 32'(oBusy), 32'h0);
    cyc();
    chk("br_c5_ack", 32'(oAck), 32'h0);
    chk("br_c5_hold", 32'(oRdData), 32'h005A);

    // word mem write A1FFE/BEEF, iSel held high throughout and must be ignored
    s_wm = n_wm;
    req(1'b1, 1'b0, 1'b1, 20'hA1FFE, 16'hBEEF);
    iSel = 1'b1; iRdData = 8'h99;
    for (int c = 1; c <= 9; c++) begin
      cyc();
      if (c == 1) iReq = 1'b0;
      chk($sformatf("ww_c%0d_wm", c), 32'(oWrMem), 32'((c == 2) || (c == 6)));
      chk($sformatf("ww_c%0d_ack", c), 32'(oAck), 32'(c == 9));
      if (c <= 4) begin
        chk($sformatf("ww_c%0d_addr", c), 32'(oAddr), 32'hA1FFE);
        chk($sformatf("ww_c%0d_data", c), 32'(oWrData), 32'hEF);
      end else if (c <= 8) begin
        chk($sformatf("ww_c%0d_addr", c), 32'(oAddr), 32'hA1FFF);
        chk($sformatf("ww_c%0d_data", c), 32'(oWrData), 32'hBE);
      end
    end
    iSel = 1'b0; iRdData = 8'h00;
    chk("ww_wm_count", 32'(n_wm - s_wm), 32'd2);
    chk("ww_rdata_kept", 32'(oRdData), 32'h005A);

    // word read at FFFFF wraps to 00000 for the high byte
    req(1'b0, 1'b0, 1'b1, 20'hFFFFF, 16'h0);
    cyc(); iReq = 1'b0;
    chk("wr_c1_addr", 32'(oAddr), 32'hFFFFF);
    cyc();
    chk("wr_c2_rm", 32'(oRdMem), 32'h1);
    cyc(); iSel = 1'b1; iRdData = 8'h11;
    cyc(); iSel = 1'b0;
    chk("wr_c4_addr", 32'(oAddr), 32'h00000);
    chk("wr_c4_ack", 32'(oAck), 32'h0);
    cyc();
    chk("wr_c5_rm", 32'(oRdMem), 32'h1);
    chk("wr_c5_addr", 32'(oAddr), 32'h00000);
    cyc(); iSel = 1'b1; iRdData = 8'h22;
    cyc(); iSel = 1'b0; iRdData = 8'h00;
    chk("wr_c7_ack", 32'(oAck), 32'h1);
    chk("wr_c7_rdata", 32'(oRdData), 32'h2211);
    cyc();

    // IO byte read 3C5 with no iSel: times out to FF
    s_ri = n_ri; s_ack = n_ack;
    req(1'b0, 1'b1, 1'b0, 20'h003C5, 16'h0);
    for (int c = 1; c <= 18; c++) begin
      cyc();
      if (c == 1) iReq = 1'b0;
      if (c == 2) chk("to_c2_ri", 32'(oRdIo), 32'h1);
      if (c == 17) chk("to_c17_ack", 32'(oAck), 32'h0);
    end
    chk("to_c18_ack", 32'(oAck), 32'h1);
    chk("to_c18_rdata", 32'(oRdData), 32'h00FF);
    cyc();
    chk("to_ri_count", 32'(n_ri - s_ri), 32'd1);
    chk("to_ack_count", 32'(n_ack - s_ack), 32'd1);

    // byte write, extra requests while busy, then a read issued on the ack cycle
    s_wm = n_wm; s_rm = n_rm;
    req(1'b1, 1'b0, 1'b0, 20'h00100, 16'h0033);
    cyc(); iReq = 1'b0;
    cyc(); req(1'b1, 1'b0, 1'b0, 20'h00200, 16'h0044);
    cyc();
    chk("pl_c3_addr", 32'(oAddr), 32'h00100);
    cyc(); iReq = 1'b0;
    cyc();
    chk("pl_c5_ack", 32'(oAck), 32'h1);
    chk("pl_c5_busy", 32'(oBusy), 32'h0);
    req(1'b0, 1'b0, 1'b0, 20'h00300, 16'h0);
    cyc(); iReq = 1'b0;
    chk("pl_c6_addr", 32'(oAddr), 32'h00300);
    chk("pl_c6_busy", 32'(oBusy), 32'h1);
    cyc();
    chk("pl_c7_rm", 32'(oRdMem), 32'h1);
    cyc(); iSel = 1'b1; iRdData = 8'h77;
    cyc(); iSel = 1'b0; iRdData = 8'h00;
    chk("pl_c9_ack", 32'(oAck), 32'h1);
    chk("pl_c9_rdata", 32'(oRdData), 32'h0077);
    cyc();
    chk("pl_wm_count", 32'(n_wm - s_wm), 32'd1);
    chk("pl_rm_count", 32'(n_rm - s_rm), 32'd1);

    // reset during the first HOLD cycle of a word write
    s_wm = n_wm; s_ack = n_ack;
    req(1'b1, 1'b0, 1'b1, 20'h12345, 16'hA55A);
    cyc(); iReq = 1'b0;
    cyc(); cyc();
    chk("rm_c3_data", 32'(oWrData), 32'h5A);
    iRst = 1'b1;
    #1;
    chk("rm_addr", 32'(oAddr), 32'h0);
    chk("rm_wdata", 32'(oWrData), 32'h0);
    chk("rm_busy", 32'(oBusy), 32'h0);
    chk("rm_rdata", 32'(oRdData), 32'h0);
    cyc(); cyc();
    iRst = 1'b0;
    repeat (8) cyc();
    chk("rm_wm_count", 32'(n_wm - s_wm), 32'd1);
    chk("rm_ack_count", 32'(n_ack - s_ack), 32'd0);
    chk("rm_idle_busy", 32'(oBusy), 32'h0);

    req(1'b0, 1'b0, 1'b0, 20'h54321, 16'h0);
    cyc(); iReq = 1'b0;
    cyc();
    chk("rm_rd_c2_rm", 32'(oRdMem), 32'h1);
    cyc(); iSel = 1'b1; iRdData = 8'hC3;
    cyc(); iSel = 1'b0; iRdData = 8'h00;
    chk("rm_rd_c4_ack", 32'(oAck), 32'h1);
    chk("rm_rd_c4_rdata", 32'(oRdData), 32'h00C3);
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
